output_port_buffer: RTL and testbench

Parametrised output-port stage for the NoC router, placed between the crossbar switch output and the link to the neighbour router. Unlike the purely combinational output stage, it stores flits in a DEPTH-entry FIFO and uses an explicit write strobe instead of "non-zero data means valid". It holds flits while the neighbour asserts `ret` (full) and drains them in order once `ret` drops. It also reports occupancy, back-pressures the switch through `full_ret`, and latches a sticky overflow error.

---
 rtl/output_port_buffer_if.sv | 28 ++
 rtl/output_port_buffer.sv | 65 ++++++
 tb/tb_output_port_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/output_port_buffer_if.sv
// Switch-to-link bus of the output-port buffer: flit/strobe in, head flit plus status out.
// The slave side is the buffer; the master side is the switch and neighbour link.
interface output_port_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] Data_in;
  logic                  wr;
  logic                  ret;
  logic                  full_ret;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  val;
  logic                  empty;
  logic [AW:0]           count;
  logic                  ovf;

  modport master (
    output Data_in, wr, ret,
    input  full_ret, Data_out, val, empty, count, ovf
  );

  modport slave (
    input  Data_in, wr, ret,
    output full_ret, Data_out, val, empty, count, ovf
  );
endinterface

// File: rtl/output_port_buffer.sv
// DEPTH-entry flit FIFO between crossbar output and link; 1-cycle write-to-head latency,
// pops stall combinationally on ret, switch is held off by full_ret (writes while full set sticky ovf).
module output_port_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output_port_buffer_if.slave     io
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic [AW:0]           cnt;
  logic                  ovf_q;
  logic                  is_empty;
  logic                  is_full;
  logic                  push;
  logic                  pop;

  assign is_empty = (cnt == '0);
  // Full comes from the registered count, so a pop from full never frees a slot for the same edge.
  assign is_full  = (cnt == (AW+1)'(DEPTH));
  assign pop      = !is_empty && !io.ret;
  assign push     = io.wr && !is_full;

  assign io.empty    = is_empty;
  assign io.full_ret = is_full;
  assign io.count    = cnt;
  assign io.val      = pop;
  assign io.ovf      = ovf_q;
  assign io.Data_out = is_empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wp] <= io.Data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (io.wr && is_full) begin
        ovf_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_output_port_buffer.sv
// Directed bench for output_port_buffer: reset, fill/stall, overflow, streaming,
// randomised-ret wrap-around against a queue model, and mid-operation reset.
module tb_output_port_buffer;
  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  output_port_buffer_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

  output_port_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_dat [4];
    logic [7:0] q [$];
    int         written;
    int         cycles;
    logic       m_pop;
    logic       m_push;

    n_err = 0;
    n_chk = 0;
    fill_dat[0] = 8'h11;
    fill_dat[1] = 8'h22;
    fill_dat[2] = 8'h33;
    fill_dat[3] = 8'h44;

    // Reset with a write presented: it must be ignored.
    rst = 1'b1;
    bus.wr = 1'b1;
    bus.Data_in = 8'hAA;
    bus.ret = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    bus.wr = 1'b0;
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_val", bus.val, 0);
    chk("rst_data", bus.Data_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_full", bus.full_ret, 0);

    // Fill while the neighbour is stalled.
    bus.ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr = 1'b1;
      bus.Data_in = fill_dat[i];
      cyc();
      chk("fill_count", bus.count, i + 1);
      chk("fill_val", bus.val, 0);
      chk("fill_head", bus.Data_out, 8'h11);
      chk("fill_full", bus.full_ret, (i == 3) ? 1 : 0);
    end

    // Write while full: dropped, sticky error.
    bus.wr = 1'b1;
    bus.Data_in = 8'h55;
    cyc();
    bus.wr = 1'b0;
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_count", bus.count, 4);
    cyc();
    chk("ovf_sticky", bus.ovf, 1);
    chk("ovf_head", bus.Data_out, 8'h11);

    // Release ret and drain in order.
    bus.ret = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", bus.val, 1);
      chk("drain_data", bus.Data_out, fill_dat[i]);
      cyc();
      chk("drain_full", bus.full_ret, 0);
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_val_end", bus.val, 0);
    chk("drain_data_end", bus.Data_out, 0);
    chk("drain_ovf", bus.ovf, 1);

    // Back-to-back streaming: simultaneous push/pop keeps occupancy at 1.
    for (int i = 1; i <= 10; i++) begin
      bus.wr = 1'b1;
      bus.Data_in = 8'(i);
      cyc();
      chk("stream_count", bus.count, 1);
      chk("stream_val", bus.val, 1);
      chk("stream_data", bus.Data_out, i);
    end
    bus.wr = 1'b0;
    cyc();
    chk("stream_empty", bus.empty, 1);

    // Wrap-around with random ret, checked against a queue model.
    written = 0;
    cycles = 0;
    while (!(written == 12 && q.size() == 0) && cycles < 400) begin
      bus.wr = (written < 12) && ($urandom_range(0, 3) != 0);
      bus.ret = ($urandom_range(0, 2) == 0);
      bus.Data_in = 8'h80 + 8'(written);
      #1;
      m_pop = (q.size() != 0) && !bus.ret;
      m_push = bus.wr && (q.size() != 4);
      chk("wrap_val", bus.val, m_pop);
      if (m_pop) begin
        chk("wrap_data", bus.Data_out, q[0]);
      end
      cyc();
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(8'h80 + 8'(written));
        written++;
      end
      chk("wrap_count", bus.count, q.size());
      cycles++;
    end
    bus.wr = 1'b0;
    bus.ret = 1'b0;
    chk("wrap_done", (written == 12 && q.size() == 0) ? 1 : 0, 1);

    // Reset with three flits stored.
    bus.ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr = 1'b1;
      bus.Data_in = 8'h31 + 8'(i);
      cyc();
    end
    bus.wr = 1'b0;
    chk("mid_pre_count", bus.count, 3);
    rst = 1'b1;
    bus.ret = 1'b0;
    bus.wr = 1'b1;
    bus.Data_in = 8'h99;
    cyc();
    rst = 1'b0;
    bus.wr = 1'b0;
    #1;
    chk("mid_empty", bus.empty, 1);
    chk("mid_val", bus.val, 0);
    chk("mid_count", bus.count, 0);
    chk("mid_ovf", bus.ovf, 0);
    bus.wr = 1'b1;
    bus.Data_in = 8'h77;
    cyc();
    bus.wr = 1'b0;
    #1;
    chk("mid_first_val", bus.val, 1);
    chk("mid_first_data", bus.Data_out, 8'h77);
    cyc();
    chk("mid_end_empty", bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
